// File: rtl/end_screen_fade_ctrl.sv
// -----------------------------------------------------------------------------
// end_screen_fade_ctrl
//
// Drives the end-screen palette path and fades it in and out. The sprite
// pixel index goes straight to the 16-entry palette ROM. The returned 4-bit
// RGB is scaled by a brightness level (0..16) that steps once every
// FRAMES_PER_STEP frame ticks. The sequence is fade-in, then hold at full
// brightness for HOLD_FRAMES ticks, then fade-out. A one-cycle done pulse
// tells the game-state FSM that the sequence has finished.
//
// Ports
//   Clk, Reset_n           pixel clock, asynchronous active-low reset
//   start                  one-cycle request to begin the sequence (IDLE only)
//   skip                   one-cycle request to jump the current phase to its end
//   vsync                  VGA vertical sync; a rising edge is one frame tick
//   blank                  1 = active video, 0 = blanking (colour forced to 0)
//   pix_index              palette index from the sprite ROM
//   pal_index              index to the palette ROM (combinational copy)
//   pal_red/green/blue     combinational palette ROM output
//   red/green/blue         scaled colour, registered (1 cycle after pix_index)
//   level                  current brightness, 0..16
//   busy                   high in FADE_IN, HOLD and FADE_OUT
//   done                   one-cycle pulse at the end of the sequence
// -----------------------------------------------------------------------------
module end_screen_fade_ctrl #(
    parameter int FRAMES_PER_STEP = 2,
    parameter int HOLD_FRAMES     = 120
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       start,
    input  logic       skip,
    input  logic       vsync,
    input  logic       blank,
    input  logic [3:0] pix_index,
    output logic [3:0] pal_index,
    input  logic [3:0] pal_red,
    input  logic [3:0] pal_green,
    input  logic [3:0] pal_blue,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [4:0] level,
    output logic       busy,
    output logic       done
);

    // Counters hold at most TERMINAL-1, so size them for that value.
    localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int HW = (HOLD_FRAMES > 1)     ? $clog2(HOLD_FRAMES)     : 1;

    localparam logic [SW-1:0] STEP_LAST = SW'(FRAMES_PER_STEP - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FADE_IN,
        HOLD,
        FADE_OUT,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [4:0]    level_n;
    logic [SW-1:0] step_cnt, step_cnt_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic          vsync_q;
    logic          tick_en;   // low for the first cycle after reset
    logic          tick;
    logic          step_evt;

    // The palette lookup is purely combinational. The colour register below
    // provides the single cycle of latency.
    assign pal_index = pix_index;

    // tick_en keeps a vsync that is already high at reset release from
    // looking like a rising edge against the cleared vsync_q.
    assign tick     = vsync & ~vsync_q & tick_en;
    assign step_evt = tick && (step_cnt == STEP_LAST);

    // floor(c * level / 16). The product is at most 15 * 16 = 240.
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lvl);
        logic [8:0] prod;
        prod = {5'd0, c} * {4'd0, lvl};
        return 4'(prod >> 4);
    endfunction

    // Next-state logic. Skip is tested before tick/step so it always wins.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_n    = state;
        level_n    = level;
        step_cnt_n = step_cnt;
        hold_cnt_n = hold_cnt;

        unique case (state)
            IDLE: begin
                level_n = 5'd0;
                if (start) state_n = FADE_IN;
            end
            FADE_IN: begin
                if (skip) begin
                    level_n = 5'd16;
                    state_n = HOLD;
                end else if (tick) begin
                    step_cnt_n = step_evt ? '0 : step_cnt + SW'(1);
                    if (step_evt) begin
                        level_n = level + 5'd1;
                        if (level == 5'd15) state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (skip) begin
                    state_n = FADE_OUT;
                end else if (tick) begin
                    if (hold_cnt == HOLD_LAST) state_n = FADE_OUT;
                    else                       hold_cnt_n = hold_cnt + HW'(1);
                end
            end
            FADE_OUT: begin
                if (skip) begin
                    level_n = 5'd0;
                    state_n = DONE;
                end else if (tick) begin
                    step_cnt_n = step_evt ? '0 : step_cnt + SW'(1);
                    if (step_evt) begin
                        level_n = level - 5'd1;
                        if (level == 5'd1) state_n = DONE;
                    end
                end
            end
            DONE: begin
                level_n = 5'd0;
                state_n = IDLE;
            end
            default: begin
                level_n = 5'd0;
                state_n = IDLE;
            end
        endcase

        // Each phase starts counting from zero.
        if (state_n != state) begin
            step_cnt_n = '0;
            hold_cnt_n = '0;
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!Reset_n) begin
            state    <= IDLE;
            level    <= 5'd0;
            step_cnt <= '0;
            hold_cnt <= '0;
            vsync_q  <= 1'b0;
            tick_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            red      <= 4'd0;
            green    <= 4'd0;
            blue     <= 4'd0;
        end else begin
            state    <= state_n;
            level    <= level_n;
            step_cnt <= step_cnt_n;
            hold_cnt <= hold_cnt_n;
            vsync_q  <= vsync;
            tick_en  <= 1'b1;
            busy     <= (state_n == FADE_IN) || (state_n == HOLD) || (state_n == FADE_OUT);
            done     <= (state_n == DONE);
            // Colour uses the level of the same cycle as pix_index.
            red      <= blank ? scale(pal_red,   level) : 4'd0;
            green    <= blank ? scale(pal_green, level) : 4'd0;
            blue     <= blank ? scale(pal_blue,  level) : 4'd0;
        end
    end

endmodule

// File: tb/tb_end_screen_fade_ctrl.sv
// -----------------------------------------------------------------------------
// tb_end_screen_fade_ctrl
//
// Self-checking bench for end_screen_fade_ctrl with FRAMES_PER_STEP = 2 and
// HOLD_FRAMES = 3. A phase/tick-count model derives the expected level, busy,
// done and colour every cycle. Directed checks pin the model with literal
// values at the points of interest.
// -----------------------------------------------------------------------------
module tb_end_screen_fade_ctrl;

    localparam int FPS  = 2;
    localparam int HOLD = 3;

    localparam int P_IDLE = 0, P_IN = 1, P_HOLD = 2, P_OUT = 3, P_DONE = 4;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       start = 1'b0, skip = 1'b0, vsync = 1'b0, blank = 1'b0;
    logic [3:0] pix_index = 4'd0;
    logic [3:0] pal_index;
    logic [3:0] pal_red, pal_green, pal_blue;
    logic [3:0] red, green, blue;
    logic [4:0] level;
    logic       busy, done;

    logic [3:0] rom_r [16];
    logic [3:0] rom_g [16];
    logic [3:0] rom_b [16];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 Clk = ~Clk;

    end_screen_fade_ctrl #(.FRAMES_PER_STEP(FPS), .HOLD_FRAMES(HOLD)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .skip(skip),
        .vsync(vsync), .blank(blank), .pix_index(pix_index),
        .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green),
        .pal_blue(pal_blue), .red(red), .green(green), .blue(blue),
        .level(level), .busy(busy), .done(done)
    );

    // Palette ROM model driven by the DUT's pal_index. Entry 7 is {F,C,5}.
    initial begin
        for (int i = 0; i < 16; i++) begin
            rom_r[i] = 4'(i);
            rom_g[i] = 4'(15 - i);
            rom_b[i] = 4'(i ^ 5);
        end
        rom_r[7] = 4'hF; rom_g[7] = 4'hC; rom_b[7] = 4'h5;
    end
    assign pal_red   = rom_r[pal_index];
    assign pal_green = rom_g[pal_index];
    assign pal_blue  = rom_b[pal_index];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase plus ticks-in-phase; brightness is derived arithmetically from
    // the tick count (fade-in: ticks/FPS, fade-out: 16 - ticks/FPS).
    int   ph, pt, m_lvl;
    bit   m_vs, m_arm, tk;
    logic [3:0] m_r, m_g, m_b;
    logic m_busy, m_done;

    always @(posedge Clk) begin
        if (!Reset_n) begin
            ph = P_IDLE; pt = 0; m_lvl = 0; m_vs = 0; m_arm = 0;
            m_r = 0; m_g = 0; m_b = 0;
        end else begin
            tk    = vsync && !m_vs && m_arm;
            m_vs  = vsync;
            m_arm = 1;
            m_r = blank ? 4'((int'(rom_r[pix_index]) * m_lvl) / 16) : 4'd0;
            m_g = blank ? 4'((int'(rom_g[pix_index]) * m_lvl) / 16) : 4'd0;
            m_b = blank ? 4'((int'(rom_b[pix_index]) * m_lvl) / 16) : 4'd0;
            case (ph)
                P_IDLE: begin
                    m_lvl = 0;
                    if (start) begin ph = P_IN; pt = 0; end
                end
                P_IN: begin
                    if (skip) begin m_lvl = 16; ph = P_HOLD; pt = 0; end
                    else if (tk) begin
                        pt++;
                        m_lvl = pt / FPS;
                        if (m_lvl == 16) begin ph = P_HOLD; pt = 0; end
                    end
                end
                P_HOLD: begin
                    if (skip) begin ph = P_OUT; pt = 0; end
                    else if (tk) begin
                        pt++;
                        if (pt == HOLD) begin ph = P_OUT; pt = 0; end
                    end
                end
                P_OUT: begin
                    if (skip) begin m_lvl = 0; ph = P_DONE; end
                    else if (tk) begin
                        pt++;
                        m_lvl = 16 - pt / FPS;
                        if (m_lvl == 0) ph = P_DONE;
                    end
                end
                default: begin m_lvl = 0; ph = P_IDLE; end
            endcase
        end
        m_busy = (ph == P_IN) || (ph == P_HOLD) || (ph == P_OUT);
        m_done = (ph == P_DONE);
        #1;
        check("model_level", 32'(level), 32'(m_lvl));
        check("model_busy",  32'(busy),  32'(m_busy));
        check("model_done",  32'(done),  32'(m_done));
        check("model_rgb",   {20'd0, red, green, blue}, {20'd0, m_r, m_g, m_b});
        check("pal_index",   32'(pal_index), 32'(pix_index));
        if (done === 1'b1) done_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic frame();
        vsync = 1'b1; cycles(2);
        vsync = 1'b0; cycles(2);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge Clk); start = 1'b0;
    endtask

    task automatic pulse_skip();
        skip = 1'b1; @(negedge Clk); skip = 1'b0;
    endtask

    task automatic check_rgb(input string name, input logic [3:0] idx, input logic bl,
                             input logic [11:0] exp);
        pix_index = idx; blank = bl;
        @(negedge Clk);
        check(name, {20'd0, red, green, blue}, {20'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset with vsync toggling, then idle with frames and no start.
        for (int i = 0; i < 4; i++) begin @(negedge Clk); vsync = ~vsync; end
        vsync = 1'b0;
        @(negedge Clk); Reset_n = 1'b1;
        check("reset_level", 32'(level), 32'd0);
        check("reset_busy",  32'(busy),  32'd0);
        frames(5);
        check("idle_level", 32'(level), 32'd0);
        check("idle_rgb",   {20'd0, red, green, blue}, 32'd0);
        check("idle_done",  32'(done_cnt), 32'd0);

        // Full sequence, pix_index 3, blank active.
        pix_index = 4'd3; blank = 1'b1;
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        frames(31);
        check("in_level_31", 32'(level), 32'd15);
        frame();
        check("in_level_32", 32'(level), 32'd16);
        frames(3);
        check("hold_end_level", 32'(level), 32'd16);
        check("hold_end_busy",  32'(busy),  32'd1);
        frames(2);
        check("out_level_2", 32'(level), 32'd15);
        frames(30);
        check("seq_done_cnt", 32'(done_cnt), 32'd1);
        check("seq_busy_end", 32'(busy), 32'd0);
        check("seq_level_end", 32'(level), 32'd0);

        // Skip at level 5 in FADE_IN.
        pulse_start();
        frames(10);
        check("skip_pre_level", 32'(level), 32'd5);
        pulse_skip();
        check("skip_in_level", 32'(level), 32'd16);
        check("skip_in_busy",  32'(busy),  32'd1);

        // Scaling at level 16 (HOLD, no ticks).
        check_rgb("scale_16", 4'd7, 1'b1, 12'hFC5);
        check_rgb("scale_blank", 4'd7, 1'b0, 12'h000);
        blank = 1'b1;

        // start during HOLD is ignored; the hold count keeps going.
        frame();
        pulse_start();
        frame();
        check("hold_start_level", 32'(level), 32'd16);
        frame();                      // third hold tick -> FADE_OUT
        frames(2);
        check("hold_start_out", 32'(level), 32'd15);
        frames(14);
        check("out_level_8", 32'(level), 32'd8);
        check_rgb("scale_8", 4'd7, 1'b1, 12'h762);
        frames(14);
        check("out_level_1", 32'(level), 32'd1);
        check_rgb("scale_1", 4'd7, 1'b1, 12'h000);

        // Skip coincident with a tick in FADE_OUT.
        vsync = 1'b1; skip = 1'b1;
        @(negedge Clk); skip = 1'b0;
        check("skip_tick_level", 32'(level), 32'd0);
        check("skip_tick_done",  32'(done),  32'd1);
        @(negedge Clk);
        check("skip_tick_done_off", 32'(done), 32'd0);
        vsync = 1'b0; cycles(2);
        check("skip_done_cnt", 32'(done_cnt), 32'd2);

        // Skip through HOLD to FADE_OUT at 16, then reset at level 9.
        pulse_start();
        pulse_skip();
        pulse_skip();
        check("skip_hold_level", 32'(level), 32'd16);
        check("skip_hold_busy",  32'(busy),  32'd1);
        frames(14);
        check("out_level_9", 32'(level), 32'd9);
        Reset_n = 1'b0;
        #1;
        check("midreset_level", 32'(level), 32'd0);
        check("midreset_busy",  32'(busy),  32'd0);
        cycles(2);
        Reset_n = 1'b1;
        frames(3);
        check("midreset_no_done", 32'(done_cnt), 32'd2);
        check("midreset_idle", 32'(busy), 32'd0);

        // vsync already high at reset release must not tick.
        @(negedge Clk); Reset_n = 1'b0; vsync = 1'b1;
        cycles(2);
        Reset_n = 1'b1;
        pulse_start();
        cycles(6);
        vsync = 1'b0; cycles(2);
        frame();                      // the only real edge so far
        check("vs_high_level", 32'(level), 32'd0);
        frame();
        check("vs_edge_level", 32'(level), 32'd1);

        Reset_n = 1'b0;
        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
